// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Parametrised 2-read/1-write register file with a per-register pending
//   scoreboard and a self-clearing sweep FSM. After reset release, or when a
//   clear is accepted, the FSM zeroes one register per cycle for DEPTH cycles.
//   During the sweep (busy=1) reads return 0 and writes/reserves are dropped.
//   Reads are combinational. Writes and reservations take effect on the
//   rising clock edge.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width; DEPTH = 2**ADDR_W registers
//   ZERO_R0  1: register 0 reads as 0, and writes/reserves to it are dropped
//
// Optional feature
//   REGFILE_SB_BYPASS_EN : when defined, a write is visible on a read port in
//                          the same cycle (write-through).
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   clear               request a clear sweep (sampled only while idle)
//   busy                sweep in progress
//   write/wrAddr/wrData write port
//   resv/resvAddr       mark a register pending
//   rdAddrA/rdDataA/pendA   read port A (data + pending flag)
//   rdAddrB/rdDataB/pendB   read port B (data + pending flag)
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              resv,
    input  logic [ADDR_W-1:0] resvAddr,
    input  logic [ADDR_W-1:0] rdAddrA,
    output logic [DATA_W-1:0] rdDataA,
    output logic              pendA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataB,
    output logic              pendB
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [DEPTH-1:0]    pending_q, pending_d;
    logic [DATA_W-1:0]   file_q [DEPTH];

    logic                sweep_we_c;
    logic                clear_acc_c;
    logic                wr_en_c;
    logic                rv_en_c;
    logic                file_we_c;
    logic [ADDR_W-1:0]   file_waddr_c;
    logic [DATA_W-1:0]   file_wdata_c;
    logic                r0_a_c;
    logic                r0_b_c;

    // Sweep FSM: CLEAR walks ptr 0..DEPTH-1, IDLE waits for a clear request
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sweep_we_c  = 1'b0;
        clear_acc_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_we_c = 1'b1;
                if (ptr_q == PTR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d     = ST_CLEAR;
                    ptr_d       = '0;
                    clear_acc_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);

    // Qualified write/reserve enables; R0 accesses are dropped when hardwired
    always_comb begin
        wr_en_c = !busy && write && !((ZERO_R0 != 0) && (wrAddr == '0));
        rv_en_c = !busy && resv  && !((ZERO_R0 != 0) && (resvAddr == '0));
    end

    // Scoreboard: a write releases, a reserve sets (reserve wins on the same
    // address because it is applied last), and an accepted clear wipes all
    always_comb begin
        pending_d = pending_q;
        if (clear_acc_c) begin
            pending_d = '0;
        end else begin
            if (wr_en_c) begin
                pending_d[wrAddr] = 1'b0;
            end
            if (rv_en_c) begin
                pending_d[resvAddr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Single array write port shared by the sweep and the functional write
    always_comb begin
        file_we_c    = 1'b0;
        file_waddr_c = wrAddr;
        file_wdata_c = wrData;
        if (sweep_we_c) begin
            file_we_c    = 1'b1;
            file_waddr_c = ptr_q[ADDR_W-1:0];
            file_wdata_c = '0;
        end else if (wr_en_c) begin
            file_we_c = 1'b1;
        end
    end

    // Storage is intentionally not reset; the sweep initialises it
    always_ff @(posedge clk) begin
        if (file_we_c) begin
            file_q[file_waddr_c] <= file_wdata_c;
        end
    end

    always_comb begin
        r0_a_c = (ZERO_R0 != 0) && (rdAddrA == '0);
        r0_b_c = (ZERO_R0 != 0) && (rdAddrB == '0);
    end

    // Read port A
    always_comb begin
        rdDataA = '0;
        pendA   = 1'b0;
        if (!busy && !r0_a_c) begin
            rdDataA = file_q[rdAddrA];
            pendA   = pending_q[rdAddrA];
`ifdef REGFILE_SB_BYPASS_EN
            if (write && (rdAddrA == wrAddr)) begin
                rdDataA = wrData;
                pendA   = resv && (resvAddr == wrAddr);
            end
`endif
        end
    end

    // Read port B
    always_comb begin
        rdDataB = '0;
        pendB   = 1'b0;
        if (!busy && !r0_b_c) begin
            rdDataB = file_q[rdAddrB];
            pendB   = pending_q[rdAddrB];
`ifdef REGFILE_SB_BYPASS_EN
            if (write && (rdAddrB == wrAddr)) begin
                rdDataB = wrData;
                pendB   = resv && (resvAddr == wrAddr);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        busy;
    logic        write;
    logic [4:0]  wrAddr;
    logic [15:0] wrData;
    logic        resv;
    logic [4:0]  resvAddr;
    logic [4:0]  rdAddrA;
    logic [15:0] rdDataA;
    logic        pendA;
    logic [4:0]  rdAddrB;
    logic [15:0] rdDataB;
    logic        pendB;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents, pending flags, remaining sweep cycles
    logic [15:0] m_file [32];
    bit          m_pend [32];
    int          m_busy;

    regfile_sb #(.DATA_W(16), .ADDR_W(5), .ZERO_R0(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .resv(resv), .resvAddr(resvAddr),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA), .pendA(pendA),
        .rdAddrB(rdAddrB), .rdDataB(rdDataB), .pendB(pendB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 32;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    function automatic logic [15:0] exp_data(input logic [4:0] a);
        if (m_busy > 0) return 16'h0;
        if (a == 5'd0) return 16'h0;
`ifdef REGFILE_SB_BYPASS_EN
        if (write && a == wrAddr) return wrData;
`endif
        return m_file[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a);
        if (m_busy > 0) return 1'b0;
        if (a == 5'd0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (write && a == wrAddr) return resv && (resvAddr == wrAddr);
`endif
        return m_pend[a];
    endfunction

    // Advance one clock edge and apply the register-file rules to the model
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_busy > 0) begin
            m_file[32 - m_busy] = 16'h0;
            m_busy--;
        end else begin
            if (write && wrAddr != 5'd0) begin
                m_file[wrAddr] = wrData;
                m_pend[wrAddr] = 1'b0;
            end
            if (resv && resvAddr != 5'd0) m_pend[resvAddr] = 1'b1;
            if (clear) model_reset();
        end
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; write = 1'b0; resv = 1'b0;
        wrAddr = '0; wrData = '0; resvAddr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rdAddrA = 5'd0; rdAddrB = 5'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", busy); end
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rdAddrA = 5'($urandom_range(1, 31));
            #1;
            n_cmp++;
            if (busy !== 1'b1 || rdDataA !== 16'h0 || pendA !== 1'b0) begin
                n_err++;
                $display("FAIL reset_sweep cyc=%0d got busy=%b data=%h pend=%b exp 1/0000/0", i, busy, rdDataA, pendA);
            end
            step();
        end
        for (int a = 0; a < 32; a += 4) begin
            rdAddrA = 5'(a); rdAddrB = 5'(a + 1);
            #1;
            n_cmp++;
            if (busy !== 1'b0 || rdDataA !== 16'h0 || rdDataB !== 16'h0) begin
                n_err++;
                $display("FAIL reset_done a=%0d got busy=%b A=%h B=%h exp 0/0000/0000", a, busy, rdDataA, rdDataB);
            end
        end
    endtask

    task automatic test_write();
        write = 1'b1; wrAddr = 5'd5; wrData = 16'hBEEF; rdAddrA = 5'd5;
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (rdDataA !== 16'hBEEF || pendA !== 1'b0) begin
            n_err++; $display("FAIL write_r5 got=%h/%b exp=beef/0", rdDataA, pendA);
        end
        write = 1'b1; wrAddr = 5'd0; wrData = 16'h1234;
        step();
        idle_inputs();
        rdAddrA = 5'd0;
        #1;
        n_cmp++;
        if (rdDataA !== 16'h0 || pendA !== 1'b0) begin
            n_err++; $display("FAIL write_r0 got=%h/%b exp=0000/0", rdDataA, pendA);
        end
    endtask

    task automatic test_resv();
        resv = 1'b1; resvAddr = 5'd7;
        step();
        idle_inputs();
        rdAddrB = 5'd7;
        #1;
        n_cmp++;
        if (pendB !== 1'b1) begin n_err++; $display("FAIL resv_r7 got=%b exp=1", pendB); end
        write = 1'b1; wrAddr = 5'd7; wrData = 16'h00AA;
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (pendB !== 1'b0 || rdDataB !== 16'h00AA) begin
            n_err++; $display("FAIL write_releases_r7 got=%h/%b exp=00aa/0", rdDataB, pendB);
        end
        write = 1'b1; wrAddr = 5'd9; wrData = 16'h0999; resv = 1'b1; resvAddr = 5'd9;
        step();
        idle_inputs();
        rdAddrB = 5'd9;
        #1;
        n_cmp++;
        if (pendB !== 1'b1 || rdDataB !== 16'h0999) begin
            n_err++; $display("FAIL resv_wins_r9 got=%h/%b exp=0999/1", rdDataB, pendB);
        end
        resv = 1'b1; resvAddr = 5'd0;
        step();
        idle_inputs();
        rdAddrB = 5'd0;
        #1;
        n_cmp++;
        if (pendB !== 1'b0) begin n_err++; $display("FAIL resv_r0 got=%b exp=0", pendB); end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_now;
`ifdef REGFILE_SB_BYPASS_EN
        exp_now = 16'h5A5A;
`else
        exp_now = 16'h0000;
`endif
        write = 1'b1; wrAddr = 5'd3; wrData = 16'h5A5A; rdAddrA = 5'd3;
        #1;
        n_cmp++;
        if (rdDataA !== exp_now || pendA !== 1'b0) begin
            n_err++; $display("FAIL bypass_same_cycle got=%h/%b exp=%h/0", rdDataA, pendA, exp_now);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (rdDataA !== 16'h5A5A) begin
            n_err++; $display("FAIL bypass_next_cycle got=%h exp=5a5a", rdDataA);
        end
    endtask

    task automatic test_clear();
        resv = 1'b1; resvAddr = 5'd5;
        step();
        idle_inputs();
        clear = 1'b1; rdAddrA = 5'd5; rdAddrB = 5'd1;
        #1;
        n_cmp++;
        if (pendA !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL clear_pre got pend=%b busy=%b exp 1/0", pendA, busy);
        end
        step();
        for (int i = 0; i < 32; i++) begin
            idle_inputs();
            if (i == 5)  clear = 1'b1;
            if (i == 10) begin write = 1'b1; wrAddr = 5'd1; wrData = 16'hFFFF; end
            #1;
            n_cmp++;
            if (busy !== 1'b1 || rdDataA !== 16'h0 || pendA !== 1'b0 || rdDataB !== 16'h0) begin
                n_err++;
                $display("FAIL clear_sweep cyc=%0d got busy=%b A=%h/%b B=%h exp 1/0000/0/0000", i, busy, rdDataA, pendA, rdDataB);
            end
            step();
        end
        idle_inputs();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rdDataA !== 16'h0 || pendA !== 1'b0 || rdDataB !== 16'h0) begin
            n_err++;
            $display("FAIL clear_after got busy=%b r5=%h/%b r1=%h exp 0/0000/0/0000", busy, rdDataA, pendA, rdDataB);
        end
    endtask

    task automatic test_reset_mid_sweep();
        clear = 1'b1;
        step();
        idle_inputs();
        repeat (12) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL mid_reset_busy got=%b exp=1", busy); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL mid_reset_sweep cyc=%0d got busy=%b exp=1", i, busy);
            end
            step();
        end
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_done got busy=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            write    = ($urandom_range(0, 1) == 1);
            resv     = ($urandom_range(0, 2) == 0);
            clear    = ($urandom_range(0, 199) == 0);
            wrAddr   = 5'($urandom);
            resvAddr = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom);
            wrData   = 16'($urandom);
            rdAddrA  = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom);
            rdAddrB  = 5'($urandom);
            #1;
            n_cmp++;
            if (busy !== (m_busy > 0) || rdDataA !== exp_data(rdAddrA) || pendA !== exp_pend(rdAddrA)
                || rdDataB !== exp_data(rdAddrB) || pendB !== exp_pend(rdAddrB)) begin
                n_err++;
                $display("FAIL random cyc=%0d busy=%b/%b A[%0d]=%h/%b exp %h/%b B[%0d]=%h/%b exp %h/%b",
                         c, busy, (m_busy > 0), rdAddrA, rdDataA, pendA, exp_data(rdAddrA), exp_pend(rdAddrA),
                         rdAddrB, rdDataB, pendB, exp_data(rdAddrB), exp_pend(rdAddrB));
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_file[i] = 16'h0;
            m_pend[i] = 1'b0;
        end
        m_busy = 32;
        @(negedge clk);
        test_reset();
        test_write();
        test_resv();
        test_bypass();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
